// File: rtl/vga_fb_arbiter_pkg.sv
// Shared VGA definitions: pixel word layout, 800x600 frame constants and arbiter state type.
package vga_pkg;

  localparam int PIX_W = 9;
  localparam int CH_W  = 3;
  localparam int R_LSB = 6;
  localparam int G_LSB = 3;
  localparam int B_LSB = 0;

  localparam int H_ACTIVE     = 800;
  localparam int V_ACTIVE     = 600;
  localparam int FRAME_PIXELS = H_ACTIVE * V_ACTIVE;

  typedef enum logic {ST_FLUSH, ST_RUN} arb_state_e;

  typedef struct packed {
    logic [CH_W-1:0] r;
    logic [CH_W-1:0] g;
    logic [CH_W-1:0] b;
  } rgb_t;

  function automatic rgb_t unpack_pix(input logic [PIX_W-1:0] w);
    rgb_t p;
    p.r = w[R_LSB +: CH_W];
    p.g = w[G_LSB +: CH_W];
    p.b = w[B_LSB +: CH_W];
    return p;
  endfunction

endpackage

// File: rtl/vga_fb_arbiter_if.sv
// CPU write port and framebuffer RAM port of the arbiter; master is the arbiter side.
interface vga_fb_arbiter_if #(
  parameter int ADDR_W = 19
);
  import vga_pkg::*;

  logic              cpu_req;
  logic [ADDR_W-1:0] cpu_addr;
  logic [PIX_W-1:0]  cpu_wdata;
  logic              cpu_ack;

  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic [PIX_W-1:0]  mem_wdata;
  logic [PIX_W-1:0]  mem_rdata;

  modport master (
    input  cpu_req, cpu_addr, cpu_wdata, mem_rdata,
    output cpu_ack, mem_addr, mem_we, mem_wdata
  );

  modport slave (
    output cpu_req, cpu_addr, cpu_wdata, mem_rdata,
    input  cpu_ack, mem_addr, mem_we, mem_wdata
  );
endinterface

// File: rtl/vga_fb_arbiter_pix_fifo.sv
// Small synchronous FIFO with occupancy count and flush; head is read combinationally.
module pix_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 9
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   flush,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       din,
  output logic [WIDTH-1:0]       dout,
  output logic [$clog2(DEPTH):0] level
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      level <= level + LVL_W'(push) - LVL_W'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= din;
  end

  assign dout = mem[rd_ptr];

endmodule

// File: rtl/vga_fb_arbiter.sv
// Framebuffer arbiter: raster-order pixel prefetch into a FIFO, CPU writes in the spare slots.
module vga_fb_arbiter
  import vga_pkg::*;
#(
  parameter int ADDR_W       = 19,
  parameter int FRAME_PIXELS = 480000,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   frame_start,
  input  logic                   de,
  vga_fb_arbiter_if.master       bus,
  output logic [CH_W-1:0]        OR,
  output logic [CH_W-1:0]        OG,
  output logic [CH_W-1:0]        OB,
  output logic                   underflow
);
  localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;
  localparam int OCC_W = LVL_W + 2;

  arb_state_e        state;
  logic [ADDR_W-1:0] fetch_addr;
  logic [1:0]        inflight;
  logic              vld_p0;
  logic              vld_p1;
  logic [LVL_W-1:0]  level;
  logic [PIX_W-1:0]  head;
  logic [OCC_W-1:0]  occ;
  logic              flush, fifo_empty, pop, push, fetch_go, cpu_go;
  rgb_t              px;

  // A frame_start cycle is itself the flush cycle, so it never grants the CPU.
  assign flush      = (state == ST_FLUSH) || frame_start;
  assign fifo_empty = (level == '0);
  assign pop        = !flush && de && !fifo_empty;
  assign push       = !flush && vld_p1;
  assign occ        = OCC_W'(level) + OCC_W'(inflight) - OCC_W'(pop);
  assign fetch_go   = !flush && (occ < OCC_W'(FIFO_DEPTH))
                      && (fetch_addr < ADDR_W'(FRAME_PIXELS));
  assign cpu_go     = !flush && !fetch_go && bus.cpu_req;
  assign px         = unpack_pix(head);

  pix_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (PIX_W)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .flush (flush),
    .push  (push),
    .pop   (pop),
    .din   (bus.mem_rdata),
    .dout  (head),
    .level (level)
  );

  // p0: read address on the RAM port; p1: RAM data returning, pushed this cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_FLUSH;
      fetch_addr  <= '0;
      inflight    <= '0;
      vld_p0      <= 1'b0;
      vld_p1      <= 1'b0;
      underflow   <= 1'b0;
      bus.cpu_ack <= 1'b0;
      bus.mem_we  <= 1'b0;
    end else begin
      state       <= ST_RUN;
      bus.cpu_ack <= cpu_go;
      bus.mem_we  <= cpu_go;
      if (flush) begin
        fetch_addr <= '0;
        inflight   <= '0;
        vld_p0     <= 1'b0;
        vld_p1     <= 1'b0;
        underflow  <= 1'b0;
      end else begin
        vld_p0   <= fetch_go;
        vld_p1   <= vld_p0;
        inflight <= inflight + 2'(fetch_go) - 2'(push);
        if (fetch_go) fetch_addr <= fetch_addr + ADDR_W'(1);
        if (de && fifo_empty) underflow <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
      OR            <= '0;
      OG            <= '0;
      OB            <= '0;
    end else begin
      if (fetch_go) begin
        bus.mem_addr <= fetch_addr;
      end else if (cpu_go) begin
        bus.mem_addr  <= bus.cpu_addr;
        bus.mem_wdata <= bus.cpu_wdata;
      end
      OR <= pop ? px.r : '0;
      OG <= pop ? px.g : '0;
      OB <= pop ? px.b : '0;
    end
  end

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Bench for vga_fb_arbiter: queue-based reference model checked every cycle, plus directed scenarios.
module tb_vga_fb_arbiter;
  import vga_pkg::*;

  localparam int ADDR_W = 19;
  localparam int FP     = 900;
  localparam int DEPTH  = 4;

  logic       clk         = 1'b0;
  logic       reset       = 1'b1;
  logic       frame_start = 1'b0;
  logic       de          = 1'b0;
  logic [2:0] OR, OG, OB;
  logic       underflow;

  vga_fb_arbiter_if #(.ADDR_W(ADDR_W)) ifc ();

  vga_fb_arbiter #(
    .ADDR_W       (ADDR_W),
    .FRAME_PIXELS (FP),
    .FIFO_DEPTH   (DEPTH)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .frame_start (frame_start),
    .de          (de),
    .bus         (ifc.master),
    .OR          (OR),
    .OG          (OG),
    .OB          (OB),
    .underflow   (underflow)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int n_ack   = 0;

  logic [PIX_W-1:0] ram [1024];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: pixel queue plus a list of reads with their arrival cycle.
  typedef struct {
    int due;
    int addr;
  } pend_t;

  pend_t             pend [$];
  logic [PIX_W-1:0]  fq   [$];
  int                cyc = 0;
  int                m_fetch = 0;
  bit                m_flush_pend = 1'b0;
  bit                m_valid = 1'b0;
  logic              e_ack = 1'b0, e_we = 1'b0, e_uf = 1'b0;
  logic [ADDR_W-1:0] e_addr = '0;
  logic [PIX_W-1:0]  e_wdata = '0, e_pix = '0;

  always @(posedge clk) begin : model_env
    bit fl, pop, iss;
    if (reset) begin
      pend.delete();
      fq.delete();
      m_fetch = 0;
      m_flush_pend = 1'b1;
      e_ack = 1'b0; e_we = 1'b0; e_uf = 1'b0;
      e_addr = '0; e_wdata = '0; e_pix = '0;
      m_valid = 1'b1;
    end else if (m_valid) begin
      fl = m_flush_pend || frame_start;
      m_flush_pend = 1'b0;
      e_ack = 1'b0;
      e_we  = 1'b0;
      if (fl) begin
        pend.delete();
        fq.delete();
        m_fetch = 0;
        e_uf = 1'b0;
        e_pix = '0;
      end else begin
        pop = de && (fq.size() > 0);
        iss = ((fq.size() + pend.size() - (pop ? 1 : 0)) < DEPTH) && (m_fetch < FP);
        if (iss) begin
          pend.push_back('{cyc + 2, m_fetch});
          e_addr = ADDR_W'(m_fetch);
          m_fetch++;
        end else if (ifc.cpu_req) begin
          e_we = 1'b1;
          e_ack = 1'b1;
          e_addr = ifc.cpu_addr;
          e_wdata = ifc.cpu_wdata;
        end
        if (pop) begin
          e_pix = fq.pop_front();
        end else begin
          e_pix = '0;
          if (de) e_uf = 1'b1;
        end
        while (pend.size() > 0 && pend[0].due == cyc) begin
          fq.push_back(ram[pend[0].addr % 1024]);
          pend.delete(0);
        end
      end
      cyc++;
    end
    ifc.mem_rdata <= ram[ifc.mem_addr[9:0]];
    if (ifc.mem_we === 1'b1) ram[ifc.mem_addr[9:0]] = ifc.mem_wdata;
  end

  always @(negedge clk) begin
    if (m_valid) begin
      check("cpu_ack",   32'(ifc.cpu_ack),   32'(e_ack));
      check("mem_we",    32'(ifc.mem_we),    32'(e_we));
      check("mem_addr",  32'(ifc.mem_addr),  32'(e_addr));
      check("mem_wdata", 32'(ifc.mem_wdata), 32'(e_wdata));
      check("pixel",     32'({OR, OG, OB}),  32'(e_pix));
      check("underflow", 32'(underflow),     32'(e_uf));
    end
  end

  // CPU requester: presents the queue head, advances on ack.
  typedef struct {
    logic [ADDR_W-1:0] a;
    logic [PIX_W-1:0]  d;
  } req_t;
  req_t rq [$];

  task automatic drive_req();
    if (rq.size() > 0) begin
      ifc.cpu_req   = 1'b1;
      ifc.cpu_addr  = rq[0].a;
      ifc.cpu_wdata = rq[0].d;
    end else begin
      ifc.cpu_req = 1'b0;
    end
  endtask

  task automatic tick();
    @(negedge clk);
    if (ifc.cpu_ack === 1'b1) begin
      n_ack++;
      if (rq.size() > 0) rq.delete(0);
    end
    drive_req();
  endtask

  logic [ADDR_W-1:0] s_addr [9];
  logic              s_ack  [9];
  logic              s_we   [9];
  logic [PIX_W-1:0]  pix    [905];
  int                ack0;

  initial begin
    ifc.cpu_req   = 1'b0;
    ifc.cpu_addr  = '0;
    ifc.cpu_wdata = '0;
    ifc.mem_rdata = '0;
    for (int i = 0; i < 1024; i++) ram[i] = PIX_W'(i % 512);

    repeat (3) tick();
    check("rst_ack",   32'(ifc.cpu_ack), 0);
    check("rst_we",    32'(ifc.mem_we), 0);
    check("rst_addr",  32'(ifc.mem_addr), 0);
    check("rst_pix",   32'({OR, OG, OB}), 0);
    check("rst_uf",    32'(underflow), 0);
    reset = 1'b0;
    repeat (10) tick();

    // Frame start with a CPU request pending and de low.
    rq.push_back('{ADDR_W'(100), 9'h1FF});
    drive_req();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    s_addr[0] = ifc.mem_addr; s_ack[0] = ifc.cpu_ack; s_we[0] = ifc.mem_we;
    for (int k = 1; k < 9; k++) begin
      tick();
      s_addr[k] = ifc.mem_addr; s_ack[k] = ifc.cpu_ack; s_we[k] = ifc.mem_we;
    end
    check("t1_fs_noack", 32'(s_ack[0]), 0);
    for (int k = 1; k <= 4; k++) begin
      check("t1_rd_addr", 32'(s_addr[k]), 32'(k - 1));
      check("t1_rd_we",   32'(s_we[k]), 0);
    end
    check("t1_ack",      32'(s_ack[5]), 1);
    check("t1_wr_addr",  32'(s_addr[5]), 100);
    check("t1_wr_we",    32'(s_we[5]), 1);
    check("t1_no_more",  32'(s_addr[8]), 100);
    check("t1_idle_we",  32'(s_we[8]), 0);
    check("t1_ram100",   32'(ram[100]), 32'h1FF);

    // Raster run of 800 pixels with a CPU request held throughout.
    for (int i = 0; i < 1024; i++) ram[i] = PIX_W'(i % 512);
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    repeat (6) tick();
    rq.push_back('{ADDR_W'(1000), 9'h0AA});
    drive_req();
    ack0 = n_ack;
    de = 1'b1;
    for (int k = 0; k < 800; k++) begin
      tick();
      pix[k] = {OR, OG, OB};
    end
    de = 1'b0;
    check("t2_pix0",   32'(pix[0]), 0);
    check("t2_pix1",   32'(pix[1]), 1);
    check("t2_pix73",  32'(pix[73]), 32'o111);
    check("t2_pix511", 32'(pix[511]), 32'h1FF);
    check("t2_pix512", 32'(pix[512]), 0);
    check("t2_pix799", 32'(pix[799]), 32'h11F);
    check("t2_uf",     32'(underflow), 0);
    check("t3_noack_in_run", 32'(n_ack - ack0), 0);
    tick();
    check("t3_ack_after_de", 32'(ifc.cpu_ack), 1);
    tick();
    check("t3_ram1000", 32'(ram[1000]), 32'h0AA);

    // Frame start with a read in flight, together with de, then de on an empty FIFO.
    de = 1'b1;
    tick();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    check("t4_fs_de_pix", 32'({OR, OG, OB}), 0);
    tick();
    de = 1'b0;
    check("t5_uf_set",  32'(underflow), 1);
    check("t5_uf_pix",  32'({OR, OG, OB}), 0);
    check("t4_addr0",   32'(ifc.mem_addr), 0);
    check("t4_rd_we",   32'(ifc.mem_we), 0);
    repeat (6) tick();
    de = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      pix[k] = {OR, OG, OB};
    end
    de = 1'b0;
    check("t4_first_pix",  32'(pix[0]), 0);
    check("t4_second_pix", 32'(pix[1]), 1);
    check("t4_fourth_pix", 32'(pix[3]), 3);
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    check("t5_uf_clear", 32'(underflow), 0);

    // Whole frame: fetch stops at FP-1, then the CPU gets consecutive slots.
    repeat (6) tick();
    de = 1'b1;
    for (int k = 0; k < 905; k++) begin
      tick();
      pix[k] = {OR, OG, OB};
      if (k == 899) check("t6_uf_last_pix", 32'(underflow), 0);
    end
    de = 1'b0;
    check("t6_pix899",  32'(pix[899]), 32'h183);
    check("t6_pix900",  32'(pix[900]), 0);
    check("t6_uf_end",  32'(underflow), 1);
    check("t6_last_rd", 32'(ifc.mem_addr), FP - 1);
    for (int k = 0; k < 4; k++) rq.push_back('{ADDR_W'(200 + k), PIX_W'(9'h100 + k)});
    drive_req();
    for (int k = 0; k < 4; k++) begin
      tick();
      check("t6_consec_ack",  32'(ifc.cpu_ack), 1);
      check("t6_consec_addr", 32'(ifc.mem_addr), 32'(200 + k));
    end
    tick();
    check("t6_ack_done", 32'(ifc.cpu_ack), 0);
    check("t6_ram203",   32'(ram[203]), 32'h103);

    // Reset arriving with a request pending: no ack for it during reset.
    rq.push_back('{ADDR_W'(300), 9'h055});
    drive_req();
    reset = 1'b1;
    tick();
    check("t7_rst_noack", 32'(ifc.cpu_ack), 0);
    check("t7_rst_we",    32'(ifc.mem_we), 0);
    reset = 1'b0;
    ack0 = n_ack;
    repeat (12) tick();
    check("t7_reack",    32'(n_ack - ack0), 1);
    check("t7_ram300",   32'(ram[300]), 32'h055);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/vga_fb_arbiter.md
# vga_fb_arbiter

Framebuffer access controller between the VGA timing counters and a shared single-port synchronous framebuffer RAM. It prefetches pixels in raster order into a small FIFO so that one pixel is available per clock while `de` is high. It also grants CPU write requests in the cycles the display fetch does not need, which in practice means horizontal and vertical blanking. Its R/G/B outputs feed the colour inputs of the VGA output stage.

## Interface
Parameters:
- `ADDR_W`, 19: framebuffer address width.
- `FRAME_PIXELS`, 480000: pixels per frame (800x600).
- `FIFO_DEPTH`, 4: prefetch FIFO entries; power of two, at least 2.

Ports:
- `clk` in 1: pixel clock; the only clock.
- `reset` in 1: synchronous, active-high.
- `frame_start` in 1: one-cycle pulse at the start of vertical sync.
- `de` in 1: display active; consumes one pixel per cycle while high.
- `cpu_req` in 1: CPU write request; held until acked.
- `cpu_addr` in ADDR_W: CPU write address.
- `cpu_wdata` in 9: CPU pixel data as {R[2:0],G[2:0],B[2:0]}.
- `cpu_ack` out 1: one-cycle pulse; the write was issued this cycle.
- `mem_addr` out ADDR_W: RAM address.
- `mem_we` out 1: RAM write enable.
- `mem_wdata` out 9: RAM write data.
- `mem_rdata` in 9: RAM read data, valid 1 cycle after the read address.
- `OR`, `OG`, `OB` out 3 each: pixel colour to the display.
- `underflow` out 1: sticky; `de` arrived while the FIFO was empty.

## Operation
- States: FLUSH and RUN.
  - Reset enters FLUSH.
  - A `frame_start` pulse enters FLUSH from any state.
  - FLUSH lasts exactly 1 cycle, then goes to RUN.
- FLUSH actions:
  - Clear the FIFO.
  - Set `fetch_addr` to 0.
  - Discard any read in flight by suppressing the FIFO push of the returning data.
  - Clear `underflow`.
  - No RAM access is issued.
- RUN, fetch slot: a read is issued when all of the following hold:
  - `level + inflight + (de ? 0 : 0) < FIFO_DEPTH`, evaluated with this cycle's pop credited (see Timing);
  - `fetch_addr < FRAME_PIXELS`.
  - Issuing sets `mem_we`=0 and `mem_addr`=`fetch_addr`, then increments `fetch_addr`.
- RUN, CPU slot: any RUN cycle without a fetch issue grants a pending `cpu_req`.
  - `mem_we`=1, `mem_addr`=`cpu_addr`, `mem_wdata`=`cpu_wdata`, `cpu_ack`=1.
  - Fetch always has priority over the CPU.
- `fetch_addr` saturates at `FRAME_PIXELS`. Once it stops, the CPU owns every remaining cycle until the next `frame_start`.
- Pop: every cycle `de`=1.
  - If the FIFO is non-empty, register the head into OR/OG/OB.
  - If the FIFO is empty, drive 0 on OR/OG/OB and set `underflow`.
- When `de`=0, OR/OG/OB are 0.
- Pixel unpack from the 9-bit word: OR=[8:6], OG=[5:3], OB=[2:0].
- CPU writes are not coherent with pixels already prefetched; this is accepted.

## Timing
- Reset values:
  - `cpu_ack`=0, `mem_we`=0, `mem_addr`=0, `mem_wdata`=0.
  - OR=OG=OB=0, `underflow`=0.
  - FIFO empty, `fetch_addr`=0, state FLUSH.
- `mem_addr`, `mem_we` and `mem_wdata` are registered. A read issued in cycle t has `mem_rdata` pushed to the FIFO at t+2 (1 cycle register + 1 cycle RAM).
- `inflight` is a 2-bit count of reads issued but not yet pushed. The fetch condition uses `level + inflight - pop < FIFO_DEPTH`, so the FIFO can never overflow.
- Pixel latency: OR/OG/OB are valid 1 cycle after the `de` cycle that consumed them. The display path delays `de` by 1 to match.
- Steady state with `de`=1: one read per cycle, zero CPU grants. With the FIFO full and `de`=0: the CPU is granted every cycle it requests.
- `cpu_ack` is high in the same cycle the write is on the registered `mem_*` outputs. The requester drops `cpu_req` or presents the next write in the following cycle.
- Simultaneous events:
  - `frame_start` together with `cpu_req`: no ack; the request stays pending.
  - `frame_start` together with `de`: FLUSH wins; pixel 0.
  - Push and pop in the same cycle: `level` is unchanged.
- Reset mid-write: the write is abandoned and `cpu_ack` is never issued for it.

## Structure
- Shared package `vga_pkg`:
  - `PIX_W`=9;
  - the pixel unpack field positions;
  - the 800x600 frame constants, which the timing counters use as well.
- One sub-module: `pix_fifo`, a synchronous FIFO (`DEPTH`, `WIDTH`, push/pop, `level`, `flush`) with no output register.
- The arbiter FSM, fetch counter and in-flight tracking live in the top level.

## Test plan
- Reset followed by `frame_start`, with `de`=0 for 10 cycles:
  - exactly 4 reads at addresses 0..3, then no more;
  - `cpu_req` with addr=100, data=0x1FF is acked in the next free cycle and writes RAM[100]=0x1FF.
- RAM preloaded with RAM[i]=i mod 512, then `de`=1 for 800 cycles: OR/OG/OB follow 0,1,2,… with a 1-cycle lag, and `underflow` stays 0.
- `cpu_req` held throughout a `de`=1 run: no ack during the run; ack within 1 cycle after `de` falls.
- `frame_start` asserted while the FIFO is full and a read is in flight:
  - FIFO empties and the stale read is dropped;
  - the next fetch address is 0.
- `de` asserted 1 cycle after FLUSH with the FIFO still empty: `underflow`=1 and OR/OG/OB=0; the next `frame_start` clears `underflow`.
- `fetch_addr` forced near the end of the frame: it stops at 479999, and afterwards the CPU is granted on consecutive cycles.
